// File: rtl/mem_access_unit.sv
// mem_access_unit: execute-side load/store engine.
// Accepts one memory op at a time, forms the effective address, steers
// byte lanes onto a word-aligned req/ack data-memory port and returns
// sign- or zero-extended load data for register writeback.
// Optional build macro: MEM_MISALIGN_EN. When it is defined, accesses that
// straddle a word boundary are split into two beats. When it is undefined,
// such accesses are rejected with err.

`ifndef OP_LOAD
`define OP_LOAD  3'd0
`endif
`ifndef OP_LOADU
`define OP_LOADU 3'd1
`endif
`ifndef OP_STORE
`define OP_STORE 3'd2
`endif

module mem_access_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [2:0]  in_width,
  input  logic [31:0] in_base,
  input  logic [31:0] in_offset,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, FINISH} state_t;

  // The wait counter counts completed stall cycles, so the abort fires in the
  // cycle where it already holds MAX_WAIT-1 and no ack arrives.
  localparam logic [31:0] WAIT_LIMIT = (MAX_WAIT == 0) ? 32'd0 : 32'(MAX_WAIT - 1);

`ifdef MEM_MISALIGN_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  state_t      state;
  logic [2:0]  op_q;
  logic [2:0]  width_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic [1:0]  off_q;
  logic        cross_q;
  logic [31:0] rdata_lo;
  logic [31:0] wait_cnt;

  logic [31:0] ea;
  logic [1:0]  in_off;
  logic [3:0]  in_end;
  logic        in_cross;
  logic        width_ok;
  logic        op_ok;
  logic [3:0]  in_mask;
  logic [3:0]  in_be;

  logic [3:0]  end_q;
  logic [3:0]  be1;
  logic [4:0]  lo_shift;
  logic [5:0]  hi_shift;
  logic [31:0] wdata1;
  logic [31:0] rdata_join;
  logic        timeout_hit;

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] w,
                                         input logic sgn);
    logic [31:0] r;
    case (w)
      3'd1:    r = {{24{sgn & d[7]}}, d[7:0]};
      3'd2:    r = {{16{sgn & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Decode the offered op: effective address, legality, crossing and first-beat enables.
  always_comb begin
    ea       = in_base + in_offset;
    in_off   = ea[1:0];
    in_end   = {2'b00, in_off} + {1'b0, in_width};
    in_cross = (in_end > 4'd4);
    width_ok = (in_width == 3'd1) || (in_width == 3'd2) || (in_width == 3'd4);
    op_ok    = (in_op == `OP_LOAD) || (in_op == `OP_LOADU) || (in_op == `OP_STORE);
    case (in_width)
      3'd1:    in_mask = 4'b0001;
      3'd2:    in_mask = 4'b0011;
      default: in_mask = 4'b1111;
    endcase
    in_be = in_cross ? (4'b1111 << in_off) : (in_mask << in_off);
  end

  // Second-beat lane steering, load-data joining and timeout detection from latched op.
  always_comb begin
    end_q       = {2'b00, off_q} + {1'b0, width_q};
    be1         = 4'b1111 >> (4'd8 - end_q);
    lo_shift    = {off_q, 3'b000};
    hi_shift    = 6'd32 - {1'b0, lo_shift};
    wdata1      = wdata_q >> hi_shift;
    rdata_join  = rdata_lo | (mem_rdata << hi_shift);
    timeout_hit = (MAX_WAIT != 0) && (wait_cnt == WAIT_LIMIT) && !mem_ack;
  end

  // Main control FSM; every port-facing output is registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      op_q      <= 3'd0;
      width_q   <= 3'd0;
      wdata_q   <= 32'd0;
      rd_q      <= 5'd0;
      off_q     <= 2'd0;
      cross_q   <= 1'b0;
      rdata_lo  <= 32'd0;
      wait_cnt  <= 32'd0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q     <= in_op;
            width_q  <= in_width;
            wdata_q  <= in_wdata;
            rd_q     <= in_rd;
            off_q    <= in_off;
            cross_q  <= in_cross;
            wait_cnt <= 32'd0;
            in_ready <= 1'b0;
            if (!width_ok || !op_ok || (in_cross && !SPLIT_EN)) begin
              state <= FINISH;
              err   <= 1'b1;
            end else begin
              state     <= BEAT0;
              mem_req   <= 1'b1;
              mem_we    <= (in_op == `OP_STORE);
              mem_addr  <= {ea[31:2], 2'b00};
              mem_be    <= in_be;
              mem_wdata <= in_wdata << {in_off, 3'b000};
            end
          end
        end
        BEAT0: begin
          if (mem_ack) begin
            wait_cnt <= 32'd0;
            if (cross_q) begin
              state     <= BEAT1;
              rdata_lo  <= mem_rdata >> lo_shift;
              mem_addr  <= mem_addr + 32'd4;
              mem_be    <= be1;
              mem_wdata <= wdata1;
            end else begin
              state   <= FINISH;
              mem_req <= 1'b0;
              done    <= 1'b1;
              if (op_q != `OP_STORE) begin
                wb_valid <= 1'b1;
                wb_rd    <= rd_q;
                wb_data  <= extend(mem_rdata >> lo_shift, width_q, op_q == `OP_LOAD);
              end
            end
          end else if (timeout_hit) begin
            state   <= FINISH;
            mem_req <= 1'b0;
            err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        BEAT1: begin
          if (mem_ack) begin
            wait_cnt <= 32'd0;
            state    <= FINISH;
            mem_req  <= 1'b0;
            done     <= 1'b1;
            if (op_q != `OP_STORE) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              wb_data  <= extend(rdata_join, width_q, op_q == `OP_LOAD);
            end
          end else if (timeout_hit) begin
            state   <= FINISH;
            mem_req <= 1'b0;
            err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        FINISH: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
// Build macro MEM_MISALIGN_EN selects which crossing-access expectations apply.

`ifndef OP_LOAD
`define OP_LOAD  3'd0
`endif
`ifndef OP_LOADU
`define OP_LOADU 3'd1
`endif
`ifndef OP_STORE
`define OP_STORE 3'd2
`endif

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [2:0]  in_width = 3'd0;
  logic [31:0] in_base = 32'd0;
  logic [31:0] in_offset = 32'd0;
  logic [31:0] in_wdata = 32'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_fail = 0;

  mem_access_unit #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_width(in_width),
    .in_base(in_base), .in_offset(in_offset), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one op for a single cycle; returns in the cycle after acceptance.
  task automatic issue(input logic [2:0] op, input logic [2:0] w, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] wdata, input logic [4:0] rd);
    in_valid  = 1'b1;
    in_op     = op;
    in_width  = w;
    in_base   = base;
    in_offset = off;
    in_wdata  = wdata;
    in_rd     = rd;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_addr !== 32'd0) begin n_fail++; $display("[TB] FAIL rst_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if ({done, err, wb_valid} !== 3'b000) begin n_fail++; $display("[TB] FAIL rst_pulses: got %b want 000", {done, err, wb_valid}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load_word();
    issue(`OP_LOAD, 3'd4, 32'h100, 32'd4, 32'd0, 5'd5);
    n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL lw_req: got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h104) begin n_fail++; $display("[TB] FAIL lw_addr: got %h want 00000104", mem_addr); end
    n_cmp++; if ({mem_we, mem_be} !== 5'b01111) begin n_fail++; $display("[TB] FAIL lw_we_be: got %b want 01111", {mem_we, mem_be}); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL lw_busy: got %b want 0", in_ready); end
    mem_ack = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 1'b0;
    n_cmp++; if ({wb_valid, done, err, mem_req} !== 4'b1100) begin n_fail++; $display("[TB] FAIL lw_pulses: got %b want 1100", {wb_valid, done, err, mem_req}); end
    n_cmp++; if (wb_data !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL lw_data: got %h want deadbeef", wb_data); end
    n_cmp++; if (wb_rd !== 5'd5) begin n_fail++; $display("[TB] FAIL lw_rd: got %0d want 5", wb_rd); end
    step();
    n_cmp++; if ({in_ready, done, wb_valid} !== 3'b100) begin n_fail++; $display("[TB] FAIL lw_idle: got %b want 100", {in_ready, done, wb_valid}); end
  endtask

  task automatic test_load_byte();
    issue(`OP_LOAD, 3'd1, 32'h200, 32'd3, 32'd0, 5'd7);
    n_cmp++; if ({mem_addr, mem_be} !== {32'h200, 4'b1000}) begin n_fail++; $display("[TB] FAIL lb_addr_be: got %h/%b want 00000200/1000", mem_addr, mem_be); end
    mem_ack = 1'b1;
    mem_rdata = 32'h80123456;
    step();
    mem_ack = 1'b0;
    n_cmp++; if (wb_data !== 32'hFFFFFF80) begin n_fail++; $display("[TB] FAIL lb_sext: got %h want ffffff80", wb_data); end
    step();
    issue(`OP_LOADU, 3'd1, 32'h200, 32'd3, 32'd0, 5'd0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    n_cmp++; if (wb_data !== 32'h00000080) begin n_fail++; $display("[TB] FAIL lbu_zext: got %h want 00000080", wb_data); end
    n_cmp++; if ({wb_valid, wb_rd} !== {1'b1, 5'd0}) begin n_fail++; $display("[TB] FAIL lbu_rd0: got %b/%0d want 1/0", wb_valid, wb_rd); end
    step();
    // halfword at byte offset 1, reached through a negative offset
    issue(`OP_LOAD, 3'd2, 32'h309, 32'hFFFFFFF8, 32'd0, 5'd3);
    n_cmp++; if ({mem_addr, mem_be} !== {32'h300, 4'b0110}) begin n_fail++; $display("[TB] FAIL lh_off1_addr_be: got %h/%b want 00000300/0110", mem_addr, mem_be); end
    mem_ack = 1'b1;
    mem_rdata = 32'h00F00D00;
    step();
    mem_ack = 1'b0;
    n_cmp++; if (wb_data !== 32'hFFFFF00D) begin n_fail++; $display("[TB] FAIL lh_off1_data: got %h want fffff00d", wb_data); end
    step();
  endtask

  task automatic test_store_half();
    issue(`OP_STORE, 3'd2, 32'h100, 32'd2, 32'h1234ABCD, 5'd4);
    n_cmp++; if ({mem_we, mem_be} !== 5'b11100) begin n_fail++; $display("[TB] FAIL sh_we_be: got %b want 11100", {mem_we, mem_be}); end
    n_cmp++; if (mem_wdata[31:16] !== 16'hABCD) begin n_fail++; $display("[TB] FAIL sh_wdata: got %h want abcd", mem_wdata[31:16]); end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    n_cmp++; if ({done, wb_valid, err} !== 3'b100) begin n_fail++; $display("[TB] FAIL sh_pulses: got %b want 100", {done, wb_valid, err}); end
    step();
  endtask

  task automatic test_misalign();
    issue(`OP_LOAD, 3'd4, 32'h0F0, 32'h0E, 32'd0, 5'd6);
`ifdef MEM_MISALIGN_EN
    n_cmp++; if ({mem_req, mem_addr, mem_be} !== {1'b1, 32'h0FC, 4'b1100}) begin n_fail++; $display("[TB] FAIL xlw_beat0: got %b/%h/%b want 1/000000fc/1100", mem_req, mem_addr, mem_be); end
    mem_ack = 1'b1;
    mem_rdata = 32'hAABB0000;
    step();
    n_cmp++; if ({mem_req, mem_addr, mem_be} !== {1'b1, 32'h100, 4'b0011}) begin n_fail++; $display("[TB] FAIL xlw_beat1: got %b/%h/%b want 1/00000100/0011", mem_req, mem_addr, mem_be); end
    mem_rdata = 32'h00002211;
    step();
    mem_ack = 1'b0;
    n_cmp++; if ({wb_valid, done, wb_data} !== {2'b11, 32'h2211AABB}) begin n_fail++; $display("[TB] FAIL xlw_data: got %b%b/%h want 11/2211aabb", wb_valid, done, wb_data); end
    step();
    // word store straddling 0x100: three bytes go to the next word
    issue(`OP_STORE, 3'd4, 32'h0FF, 32'd0, 32'h11223344, 5'd0);
    n_cmp++; if ({mem_be, mem_wdata} !== {4'b1000, 32'h44000000}) begin n_fail++; $display("[TB] FAIL xsw_beat0: got %b/%h want 1000/44000000", mem_be, mem_wdata); end
    mem_ack = 1'b1;
    step();
    n_cmp++; if ({mem_addr, mem_be, mem_wdata} !== {32'h100, 4'b0111, 32'h00112233}) begin n_fail++; $display("[TB] FAIL xsw_beat1: got %h/%b/%h want 00000100/0111/00112233", mem_addr, mem_be, mem_wdata); end
    step();
    mem_ack = 1'b0;
    n_cmp++; if ({done, wb_valid} !== 2'b10) begin n_fail++; $display("[TB] FAIL xsw_done: got %b want 10", {done, wb_valid}); end
    step();
    // address wrap at the top of memory
    issue(`OP_LOAD, 3'd4, 32'hFFFFFFFE, 32'd0, 32'd0, 5'd8);
    n_cmp++; if (mem_addr !== 32'hFFFFFFFC) begin n_fail++; $display("[TB] FAIL wrap_beat0: got %h want fffffffc", mem_addr); end
    mem_ack = 1'b1;
    mem_rdata = 32'h12340000;
    step();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("[TB] FAIL wrap_beat1: got %b/%h want 1/00000000", mem_req, mem_addr); end
    mem_rdata = 32'h00005678;
    step();
    mem_ack = 1'b0;
    n_cmp++; if (wb_data !== 32'h56781234) begin n_fail++; $display("[TB] FAIL wrap_data: got %h want 56781234", wb_data); end
    step();
`else
    n_cmp++; if ({err, done, mem_req} !== 3'b100) begin n_fail++; $display("[TB] FAIL xlw_reject: got %b want 100", {err, done, mem_req}); end
    step();
    n_cmp++; if ({in_ready, mem_req} !== 2'b10) begin n_fail++; $display("[TB] FAIL xlw_noreq: got %b want 10", {in_ready, mem_req}); end
`endif
  endtask

  task automatic test_timeout();
    mem_ack = 1'b0;
    issue(`OP_LOAD, 3'd4, 32'h400, 32'd0, 32'd0, 5'd2);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL to_req_cycle%0d: got %b want 1", i, mem_req); end
      step();
    end
    n_cmp++; if ({mem_req, err, done, wb_valid} !== 4'b0100) begin n_fail++; $display("[TB] FAIL to_abort: got %b want 0100", {mem_req, err, done, wb_valid}); end
    step();
    n_cmp++; if ({in_ready, err} !== 2'b10) begin n_fail++; $display("[TB] FAIL to_idle: got %b want 10", {in_ready, err}); end
  endtask

  task automatic test_invalid();
    issue(`OP_LOAD, 3'd3, 32'h500, 32'd0, 32'd0, 5'd1);
    n_cmp++; if ({err, mem_req, done} !== 3'b100) begin n_fail++; $display("[TB] FAIL bad_width: got %b want 100", {err, mem_req, done}); end
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_width_idle: got %b want 1", in_ready); end
    issue(3'd7, 3'd4, 32'h500, 32'd0, 32'd0, 5'd1);
    n_cmp++; if ({err, mem_req} !== 2'b10) begin n_fail++; $display("[TB] FAIL bad_op: got %b want 10", {err, mem_req}); end
    step();
  endtask

  task automatic test_back_to_back();
    issue(`OP_LOAD, 3'd4, 32'h800, 32'd0, 32'd0, 5'd1);
    // a second offer while busy must be ignored, and the request must hold steady
    in_valid = 1'b1;
    in_op = `OP_STORE;
    in_base = 32'h900;
    step();
    n_cmp++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h800}) begin n_fail++; $display("[TB] FAIL b2b_stall: got %b%b/%h want 10/00000800", mem_req, mem_we, mem_addr); end
    mem_ack = 1'b1;
    mem_rdata = 32'h11112222;
    step();
    mem_ack = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if ({done, wb_data} !== {1'b1, 32'h11112222}) begin n_fail++; $display("[TB] FAIL b2b_first: got %b/%h want 1/11112222", done, wb_data); end
    step();
    n_cmp++; if ({in_ready, mem_req} !== 2'b10) begin n_fail++; $display("[TB] FAIL b2b_not_queued: got %b want 10", {in_ready, mem_req}); end
    issue(`OP_LOAD, 3'd4, 32'h804, 32'd0, 32'd0, 5'd2);
    n_cmp++; if (mem_addr !== 32'h804) begin n_fail++; $display("[TB] FAIL b2b_second_addr: got %h want 00000804", mem_addr); end
    mem_ack = 1'b1;
    mem_rdata = 32'h33334444;
    step();
    mem_ack = 1'b0;
    n_cmp++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd2, 32'h33334444}) begin n_fail++; $display("[TB] FAIL b2b_second: got %b/%0d/%h want 1/2/33334444", wb_valid, wb_rd, wb_data); end
    step();
  endtask

  task automatic test_reset_midflight();
    issue(`OP_STORE, 3'd4, 32'h600, 32'd0, 32'hFFFFFFFF, 5'd0);
    n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_req: got %b want 1", mem_req); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if ({in_ready, mem_req, mem_we, mem_be} !== 7'b1000000) begin n_fail++; $display("[TB] FAIL mid_reset: got %b want 1000000", {in_ready, mem_req, mem_we, mem_be}); end
    n_cmp++; if ({mem_addr, mem_wdata} !== 64'd0) begin n_fail++; $display("[TB] FAIL mid_reset_bus: got %h/%h want 0/0", mem_addr, mem_wdata); end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    n_cmp++; if ({done, err, wb_valid, in_ready} !== 4'b0001) begin n_fail++; $display("[TB] FAIL stale_ack: got %b want 0001", {done, err, wb_valid, in_ready}); end
    issue(`OP_LOAD, 3'd4, 32'h700, 32'd0, 32'd0, 5'd9);
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 1'b0;
    n_cmp++; if ({done, wb_rd, wb_data} !== {1'b1, 5'd9, 32'hCAFEF00D}) begin n_fail++; $display("[TB] FAIL post_reset_lw: got %b/%0d/%h want 1/9/cafef00d", done, wb_rd, wb_data); end
    step();
  endtask

  initial begin
    $display("[TB] starting mem_access_unit bench");
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_timeout();
    test_invalid();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Execute-side load/store engine: consumes memory ops issued for `EX_MEM_UNIT (op, width, offset, rs1/rs2 values, rd) and runs word-aligned, byte-enabled transactions on a req/ack data-memory port.
- Returns sign- or zero-extended load data to register-file writeback.
- Sits between issue/operand fetch and data memory.
- Owns effective-address generation, lane steering, timeout, and optional splitting of word-crossing accesses.

Parameters:
- MAX_WAIT, 255: cycles mem_req may stay high without mem_ack before abort. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  op offered
- in_ready  out  1  unit idle and able to accept
- in_op  in  3  `OP_LOAD / `OP_LOADU / `OP_STORE (common_def.h)
- in_width  in  3  access bytes: 1, 2 or 4
- in_base  in  32  rs1 value
- in_offset  in  32  sign-extended offset
- in_wdata  in  32  rs2 value (store data, low-aligned)
- in_rd  in  5  load destination
- mem_req  out  1  transaction request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-steered store data
- mem_ack  in  1  transaction complete; mem_rdata valid this cycle for reads
- mem_rdata  in  32  read data
- wb_valid  out  1  one-cycle load result pulse
- wb_rd  out  5  destination
- wb_data  out  32  extended load data
- done  out  1  one-cycle pulse on successful completion of any op
- err  out  1  one-cycle pulse on rejected or aborted op

Behaviour:
- Reset (rst_n low at posedge):
  - state := IDLE; every output 0 except in_ready, which is 1 after reset.
  - Any in-flight transaction is dropped and its late mem_ack ignored.
- States: IDLE, BEAT0, BEAT1, FINISH.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch all inputs and compute ea = in_base + in_offset mod 2^32, off = ea[1:0].
  - Invalid width (not 1, 2 or 4) or invalid op: go to FINISH with err, no memory access.
  - Otherwise go to BEAT0.
- Crossing access: off + width > 4.
- BEAT0:
  - mem_req = 1, mem_addr = {ea[31:2], 2'b00}, mem_we = store.
  - Non-crossing: mem_be has `width` ones starting at bit `off`.
  - Crossing: mem_be = ones from bit `off` to bit 3.
  - mem_wdata = in_wdata << 8*off.
  - All request fields stay stable until mem_ack.
  - On mem_ack: crossing → BEAT1; else → FINISH.
- BEAT1 (crossing only):
  - mem_addr = previous word address + 4, wrapping 0xFFFFFFFC → 0x00000000.
  - mem_be = ones at bits 0 .. off+width-5.
  - mem_wdata = in_wdata >> 8*(4-off).
  - mem_req stays high across the beat boundary (no idle cycle).
  - On mem_ack → FINISH.
- FINISH (exactly one cycle, in_ready = 0, mem_req = 0):
  - Pulse done, or err.
  - Loads that succeed also pulse wb_valid with wb_rd = latched rd; rd = 0 still pulses.
  - Then return to IDLE.
- Load data:
  - Bytes gathered in address order: BEAT0 bytes off..3, then BEAT1 bytes 0..
  - `OP_LOAD sign-extends from bit 8*width-1; `OP_LOADU zero-extends.
  - width = 4 needs no extension.
- Latency: accept at edge N; mem_req high from cycle N+1; ack in cycle N+1 gives done/wb in cycle N+2. Minimum 3 cycles per op, 4 when split.
- Timeout (MAX_WAIT > 0):
  - A counter increments each cycle mem_req is high without mem_ack.
  - At MAX_WAIT: drop mem_req, go to FINISH with err, no wb.
  - A partially completed split store is not rolled back.
  - The counter resets every beat.
- Other cases:
  - mem_ack while mem_req is low is ignored.
  - in_valid while in_ready is low is ignored; it is not queued.
  - At most one op is outstanding.

Optional Feature:
- MEM_MISALIGN_EN defined: crossing accesses are split into BEAT0/BEAT1 as above.
- Undefined: a crossing access goes IDLE → FINISH with err, issues no mem_req, and never enters BEAT1.
- Non-crossing misaligned accesses (e.g. halfword at off = 1) are legal in both builds.

Test Plan:
1. LW: base 0x100, offset 4, ack in the first req cycle, rdata 0xDEADBEEF → mem_addr 0x104, be 1111, we 0; wb_valid + done two cycles after accept, wb_data 0xDEADBEEF, wb_rd = in_rd.
2. LB at ea 0x203, rdata 0x80123456 → be 1000, wb_data 0xFFFFFF80. Same access with LBU → 0x00000080.
3. SH at ea 0x102, wdata 0x1234ABCD → be 1100, mem_wdata[31:16] = 0xABCD, we 1; done pulses, wb_valid stays 0.
4. LW at ea 0x0FE:
   - With MEM_MISALIGN_EN: beat0 addr 0x0FC, be 1100, rdata 0xAABB0000; beat1 addr 0x100, be 0011, rdata 0x00002211 → wb_data 0x2211AABB.
   - Without MEM_MISALIGN_EN: err pulse, mem_req never rises.
5. MAX_WAIT = 4, mem_ack held 0 → mem_req high exactly 4 cycles, then err pulse, in_ready = 1 the cycle after. Width = 3 op → err, no req.
6. rst_n low during BEAT0 → all outputs 0 at the next edge, in_ready = 1; a stale mem_ack is ignored; the next LW completes normally. Also ea 0xFFFFFFFE LW (MEM_MISALIGN_EN) → beat1 addr 0x00000000.
